alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Pipelined, parametrised successor to the combinational ALU operand-2 select: resolves both ALU operands (register/immediate/PC/zero), applies register forwarding from up to NUM_FWD later pipeline stages, and registers the result into a two-entry skid buffer. It sits between decode/register-read and the ALU. It uses a valid/ready handshake, so the back-end can stall without combinational ready paths reaching decode.

## Interface
- XLEN, 32: data width of all operands.
- NUM_FWD, 2: number of forwarding sources; index 0 is the youngest and has the highest priority.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  decode presents an operation.
- in_ready  out  1  stage can accept; registered output.
- alu_src1  in  2  op1 select: 0 = reg_data1, 1 = pc, 2 = zero, 3 = zero.
- alu_src2  in  2  op2 select: 0 = reg_data2, 1 = imm, 2 = pc, 3 = zero.
- rs1, rs2  in  5 each  source register indices.
- reg_data1, reg_data2  in  XLEN each  register-file read data.
- imm, pc  in  XLEN each  immediate and instruction address.
- fwd_valid  in  NUM_FWD  per-source forward enable.
- fwd_rd  in  5*NUM_FWD  destination index per source; source i occupies bits [5i+4:5i].
- fwd_data  in  XLEN*NUM_FWD  result per source; source i occupies bits [XLEN*i+XLEN-1:XLEN*i].
- out_valid  out  1  an entry is presented to the ALU.
- out_ready  in  1  ALU accepts.
- op1, op2  out  XLEN each  resolved operands.
- store_data  out  XLEN  forwarded rs2 value, regardless of alu_src2.

## Operation
- Forwarding resolve, combinational on inputs: for rs1 and rs2 independently, pick the lowest index i with fwd_valid[i] = 1, fwd_rd[i] equal to the source index, and the source index not equal to 0.
  - If a match is found, the value is fwd_data[i]. Otherwise it is reg_data1 or reg_data2.
  - Register 0 is never forwarded, so its value is always the read data.
- Operand select, applied after forwarding:
  - op1 per alu_src1.
  - op2 per alu_src2. Source 0 uses the forwarded rs2 value.
  - store_data is always the forwarded rs2 value.
- Accept: in_valid and in_ready in the same cycle. Operands are captured at the accept edge. Forwarding inputs are sampled only in the accept cycle.
- Buffer: two entries, main and skid. Output always comes from main.
  - Accept while main is empty, or while main drains (out_ready = 1): the entry goes to main.
  - Accept while main is full and stalled: the entry goes to skid.
  - in_ready next cycle = skid empty after the update.
- Drain: out_valid and out_ready pop main. If skid is full, skid moves to main in the same edge.
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush.
- flush = 1: at the next edge both entries are invalid, out_valid = 0, in_ready = 1.
  - Any accept in the flush cycle is discarded.
  - out_ready is ignored in the flush cycle.
- The data registers of invalid entries keep their stale values and are never observed as valid.

## Timing
- Reset values, asynchronous on rst_n low: out_valid = 0, in_ready = 1, op1 = op2 = store_data = 0, skid empty.
- Latency: 1 cycle. An entry accepted at edge N has out_valid = 1 after edge N.
- Throughput: 1 operation per cycle while out_ready = 1.
- Stall: out_ready = 0 with main full.
  - op1, op2 and store_data hold stable.
  - One further accept goes to skid; in_ready drops after that edge.
- Skid full, out_ready rises: after the edge main = old skid, skid empty, in_ready = 1.
  - If in_valid was also high in that cycle, there was no accept, because in_ready was 0.
- Full case, out_ready = 1, in_valid = 1, in_ready = 1, main full, skid empty: main takes the new entry; occupancy is unchanged.
- Reset released mid-operation: the first edge after deassertion may accept; no entry survives reset.
- No combinational path from out_ready to in_ready.

## Test plan
- Basic select: rs1 = 3, reg_data1 = 0x10, alu_src1 = 0, alu_src2 = 1, imm = 0xFFFF_FFF0, out_ready = 1 -> one cycle later out_valid = 1, op1 = 0x10, op2 = 0xFFFF_FFF0. Repeat with alu_src2 = 2 and pc = 0x400 -> op2 = 0x400. Repeat with alu_src2 = 3 -> op2 = 0.
- Forward priority: rs2 = 5, fwd_valid = 2'b11, fwd_rd = {5, 5}, fwd_data = {0xBBBB, 0xAAAA} -> op2 = 0xAAAA and store_data = 0xAAAA. Drive fwd_valid = 2'b10 -> 0xBBBB.
- x0 guard: rs1 = 0, reg_data1 = 0, fwd_valid[0] = 1, fwd_rd[0] = 0, fwd_data[0] = 0x1234 -> op1 = 0.
- Back-pressure: stream A, B, C with out_ready = 0 -> in_ready = 0 after B is accepted, C is held, op1 stays A. Raise out_ready -> outputs A, B, C in order, 1 per cycle, none lost.
- Flush: main = A and skid = B, pulse flush with in_valid = 1 carrying C -> next cycle out_valid = 0, in_ready = 1, C never appears on the output.
- Async reset: assert rst_n = 0 mid-stream between clock edges -> out_valid = 0 and outputs = 0 immediately. After release, a new entry emerges with 1-cycle latency.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Resolves both ALU operands with register forwarding. The result is
// registered into a two-entry (main + skid) buffer that sits between
// register-read and the ALU.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable until that
// edge. in_ready comes straight from a flop, so out_ready never reaches
// decode combinationally.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of both buffered entries
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   alu_src1              op1 select: 0 reg_data1, 1 pc, 2/3 zero
//   alu_src2              op2 select: 0 reg_data2, 1 imm, 2 pc, 3 zero
//   rs1, rs2              source register indices
//   reg_data1, reg_data2  register-file read data
//   imm, pc               immediate and instruction address
//   fwd_valid/rd/data     NUM_FWD forwarding sources, index 0 youngest
//   out_valid / out_ready downstream handshake
//   op1, op2, store_data  resolved operands and forwarded rs2 value
// ---------------------------------------------------------------------------
module alu_operand_stage #(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              alu_src1,
   input  logic [1:0]              alu_src2,
   input  logic [4:0]              rs1,
   input  logic [4:0]              rs2,
   input  logic [XLEN-1:0]         reg_data1,
   input  logic [XLEN-1:0]         reg_data2,
   input  logic [XLEN-1:0]         imm,
   input  logic [XLEN-1:0]         pc,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [5*NUM_FWD-1:0]    fwd_rd,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         op1,
   output logic [XLEN-1:0]         op2,
   output logic [XLEN-1:0]         store_data
);

   logic [XLEN-1:0] fwd1, fwd2;
   logic            hit1, hit2;
   logic [XLEN-1:0] sel1, sel2;

   // Forwarding: the first matching source from index 0 upward wins, so the
   // hit flag blocks any older source. x0 never forwards.
   always_comb begin
      fwd1 = reg_data1;
      fwd2 = reg_data2;
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (!hit1 && fwd_valid[i] && (fwd_rd[5*i +: 5] == rs1) && (rs1 != 5'd0)) begin
            fwd1 = fwd_data[XLEN*i +: XLEN];
            hit1 = 1'b1;
         end
         if (!hit2 && fwd_valid[i] && (fwd_rd[5*i +: 5] == rs2) && (rs2 != 5'd0)) begin
            fwd2 = fwd_data[XLEN*i +: XLEN];
            hit2 = 1'b1;
         end
      end
   end

   always_comb begin
      sel1 = '0;
      case (alu_src1)
         2'd0:    sel1 = fwd1;
         2'd1:    sel1 = pc;
         default: sel1 = '0;
      endcase
   end

   always_comb begin
      sel2 = '0;
      case (alu_src2)
         2'd0:    sel2 = fwd2;
         2'd1:    sel2 = imm;
         2'd2:    sel2 = pc;
         default: sel2 = '0;
      endcase
   end

   // Buffer state
   logic            main_valid, skid_valid;
   logic [XLEN-1:0] main_op1, main_op2, main_sd;
   logic [XLEN-1:0] skid_op1, skid_op2, skid_sd;
   logic            accept, pop;

   // The skid entry is only ever full while main is full, so "skid empty"
   // is exactly the ready condition and is already a flop output.
   assign in_ready   = ~skid_valid;
   assign out_valid  = main_valid;
   assign op1        = main_op1;
   assign op2        = main_op2;
   assign store_data = main_sd;

   assign accept = in_valid & in_ready & ~flush;
   assign pop    = main_valid & out_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_op1   <= '0;
         main_op2   <= '0;
         main_sd    <= '0;
         skid_op1   <= '0;
         skid_op2   <= '0;
         skid_sd    <= '0;
      end else if (flush) begin
         // Data registers keep stale contents; only the valid bits clear.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (pop) begin
         if (skid_valid) begin
            // in_ready was low, so no accept can coincide with this refill.
            main_op1   <= skid_op1;
            main_op2   <= skid_op2;
            main_sd    <= skid_sd;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_op1 <= sel1;
            main_op2 <= sel2;
            main_sd  <= fwd2;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         if (!main_valid) begin
            main_op1   <= sel1;
            main_op2   <= sel2;
            main_sd    <= fwd2;
            main_valid <= 1'b1;
         end else begin
            skid_op1   <= sel1;
            skid_op2   <= sel2;
            skid_sd    <= fwd2;
            skid_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   localparam int XLEN    = 32;
   localparam int NUM_FWD = 2;

   logic                    clk;
   logic                    rst_n;
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              alu_src1, alu_src2;
   logic [4:0]              rs1, rs2;
   logic [XLEN-1:0]         reg_data1, reg_data2, imm, pc;
   logic [NUM_FWD-1:0]      fwd_valid;
   logic [5*NUM_FWD-1:0]    fwd_rd;
   logic [XLEN*NUM_FWD-1:0] fwd_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         op1, op2, store_data;

   alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_src1(alu_src1), .alu_src2(alu_src2),
      .rs1(rs1), .rs2(rs2),
      .reg_data1(reg_data1), .reg_data2(reg_data2),
      .imm(imm), .pc(pc),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .op1(op1), .op2(op2), .store_data(store_data)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   // Each expected entry is {op1, op2, store_data}; head is what the ALU sees.
   logic [3*XLEN-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: the value a source register holds as seen by this
   // instruction, from the youngest matching producer, else the register file.
   function automatic logic [XLEN-1:0] src_value(input logic [4:0] r, input logic [XLEN-1:0] rf);
      if (r == 5'd0) return rf;
      for (int i = 0; i < NUM_FWD; i++)
         if (fwd_valid[i] && fwd_rd[5*i +: 5] == r) return fwd_data[XLEN*i +: XLEN];
      return rf;
   endfunction

   function automatic logic [3*XLEN-1:0] model_entry();
      logic [XLEN-1:0] v1, v2, a, b;
      v1 = src_value(rs1, reg_data1);
      v2 = src_value(rs2, reg_data2);
      a = (alu_src1 == 2'd0) ? v1 : (alu_src1 == 2'd1) ? pc : '0;
      b = (alu_src2 == 2'd0) ? v2 : (alu_src2 == 2'd1) ? imm : (alu_src2 == 2'd2) ? pc : '0;
      return {a, b, v2};
   endfunction

   task automatic compare_outputs();
      logic [3*XLEN-1:0] h;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
         h = exp_q[0];
         check("op1", op1, h[3*XLEN-1:2*XLEN]);
         check("op2", op2, h[2*XLEN-1:XLEN]);
         check("store_data", store_data, h[XLEN-1:0]);
      end
   endtask

   // One clock: decide the model's accept/pop from the pre-edge state, take
   // the edge, update the model and compare.
   task automatic step();
      logic acc, pop;
      logic [3*XLEN-1:0] e;
      acc = in_valid && (exp_q.size() < 2) && !flush;
      pop = (exp_q.size() > 0) && out_ready && !flush;
      e   = model_entry();
      @(posedge clk);
      #1;
      if (flush) exp_q.delete();
      else begin
         if (pop) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(e);
      end
      compare_outputs();
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      flush = 0; in_valid = 0; out_ready = 0;
      alu_src1 = 0; alu_src2 = 0; rs1 = 0; rs2 = 0;
      reg_data1 = 0; reg_data2 = 0; imm = 0; pc = 0;
      fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
   endtask

   task automatic drive_pc_op(input logic [XLEN-1:0] tag);
      in_valid = 1; alu_src1 = 2'd1; alu_src2 = 2'd3; pc = tag;
      rs1 = 0; rs2 = 0; fwd_valid = 0;
   endtask

   task automatic rand_inputs();
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      alu_src1  = 2'($urandom_range(0, 3));
      alu_src2  = 2'($urandom_range(0, 3));
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
      reg_data1 = $urandom; reg_data2 = $urandom;
      imm       = $urandom; pc = $urandom;
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_rd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      fwd_data  = {$urandom, $urandom};
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      rst_n = 0;
      #12;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      check("reset_op1", op1, 32'd0);
      check("reset_op2", op2, 32'd0);
      check("reset_store_data", store_data, 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;

      // basic select
      in_valid = 1; out_ready = 1; rs1 = 5'd3; reg_data1 = 32'h10;
      alu_src1 = 0; alu_src2 = 1; imm = 32'hFFFF_FFF0;
      step();
      check("basic_valid", {31'd0, out_valid}, 32'd1);
      check("basic_op1", op1, 32'h10);
      check("basic_op2_imm", op2, 32'hFFFF_FFF0);
      alu_src2 = 2; pc = 32'h400;
      step();
      check("basic_op2_pc", op2, 32'h400);
      alu_src2 = 3;
      step();
      check("basic_op2_zero", op2, 32'h0);

      // forward priority
      rs2 = 5'd5; alu_src2 = 0; reg_data2 = 32'h5555;
      fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'hBBBB, 32'hAAAA};
      step();
      check("fwd_young_op2", op2, 32'hAAAA);
      check("fwd_young_sd", store_data, 32'hAAAA);
      fwd_valid = 2'b10;
      step();
      check("fwd_old_op2", op2, 32'hBBBB);

      // x0 guard
      rs1 = 0; reg_data1 = 0; alu_src1 = 0;
      fwd_valid = 2'b01; fwd_rd = {5'd9, 5'd0}; fwd_data = {32'h0, 32'h1234};
      step();
      check("x0_guard", op1, 32'h0);

      // back-pressure A, B, C
      in_valid = 0; step();
      out_ready = 0;
      drive_pc_op(32'hA); step();
      drive_pc_op(32'hB); step();
      check("bp_ready_low", {31'd0, in_ready}, 32'd0);
      drive_pc_op(32'hC); step();
      check("bp_hold_a", op1, 32'hA);
      out_ready = 1; step();
      check("bp_out_b", op1, 32'hB);
      step();
      check("bp_out_c", op1, 32'hC);
      in_valid = 0; step();
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // flush with main = A, skid = B, C offered during flush
      out_ready = 0;
      drive_pc_op(32'hA); step();
      drive_pc_op(32'hB); step();
      flush = 1; drive_pc_op(32'hC); step();
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_ready", {31'd0, in_ready}, 32'd1);
      flush = 0; in_valid = 0; out_ready = 1;
      for (int i = 0; i < 3; i++) step();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rand_inputs();
         step();
      end

      // async reset mid-stream
      flush = 0; out_ready = 0;
      drive_pc_op(32'hD); step();
      in_valid = 0;
      #2 rst_n = 0;
      #1;
      exp_q.delete();
      check("areset_valid", {31'd0, out_valid}, 32'd0);
      check("areset_op1", op1, 32'd0);
      check("areset_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      out_ready = 1;
      drive_pc_op(32'hE); step();
      check("post_reset_op1", op1, 32'hE);
      in_valid = 0; step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
